tt_uio_byte_reader: RTL and testbench
=====================================

Name: tt_uio_byte_reader

Overview:
- Receiving end of the parallel byte interface on the bidirectional uio pins.
- An off-chip writer drives a byte on uio_in and toggles a request strobe on a dedicated ui_in pin under a 4-phase req/ack handshake.
- This block synchronises the strobe, captures each byte into a small FIFO, acknowledges on a dedicated uo_out pin, and presents bytes to on-chip logic through a show-ahead read port.
- Instantiated inside the tt_um_* top. Top wiring: uio_oe driven from bus_oe; strobe on ui_in[0]; ack on uo_out[7].

Parameters:
- DEPTH, 4, FIFO depth in bytes; power of two, 2..16.
- SYNC_STAGES, 2, flops in the strobe synchroniser; minimum 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- bus_data_in  in  8  byte from uio_in; stable while bus_stb_in is high, per protocol.
- bus_stb_in  in  1  asynchronous request from writer.
- bus_ack_out  out  1  acknowledge to writer; registered.
- bus_oe  out  8  uio output enables; constant 8'h00 (uio is input-only here).
- rd_en  in  1  pop request from on-chip consumer.
- rd_data  out  8  FIFO head byte (show-ahead).
- rd_valid  out  1  FIFO not empty.
- fifo_count  out  clog2(DEPTH)+1  current occupancy.
- rx_count  out  8  total bytes accepted since reset; wraps 255->0.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - bus_ack_out=0, rd_valid=0, fifo_count=0, rx_count=0.
  - rd_data=8'h00; FIFO pointers 0.
  - Synchroniser flops reset to 1, so the strobe is treated as asserted. FSM resets to ARM.
- stb_s is the last synchroniser flop. Input-to-stb_s latency is SYNC_STAGES cycles.
- FSM states and transitions:
  - ARM: wait for stb_s==0, then go to IDLE. Prevents re-capturing a byte whose strobe is still held across a reset.
  - IDLE, stb_s==1 && !full: push bus_data_in, rx_count+=1, go to ACK.
  - IDLE, stb_s==1 && full: go to HOLD.
  - HOLD: on !full, push, rx_count+=1, go to ACK. bus_ack_out stays 0 throughout HOLD; this is the backpressure mechanism.
  - ACK: bus_ack_out=1 (asserted the cycle after the push). On stb_s==0, go to IDLE; bus_ack_out=0 the following cycle.
- Exactly one push per 4-phase transaction. Strobe glitches while in ACK are ignored.
- Bus data is sampled directly (not synchronised). The protocol guarantees stability from strobe rise to ack seen.
- FIFO rules:
  - full = (fifo_count==DEPTH), registered occupancy. A same-cycle pop does not make room for a push; the push waits one cycle.
  - rd_en with rd_valid==0 is ignored.
  - Push and pop in the same cycle (0<count<DEPTH): count unchanged, both pointers advance.
  - Push into an empty FIFO: rd_valid=1 and rd_data valid the next cycle.
  - Pointers wrap modulo DEPTH.
- Mid-operation reset: ack drops, FIFO empties and rx_count clears on the next edge. FSM re-enters ARM and waits for the writer to release the strobe.

Decomposition:
- Shared package tt_uio_pkg holds:
  - FSM state encoding (ARM, IDLE, HOLD, ACK; 2 bits).
  - Pin-map constants STB_PIN=0 and ACK_PIN=7.
  - UIO_OE_INPUT=8'h00.
- One sub-module, tt_byte_fifo:
  - Parameterised DEPTH.
  - Ports: push/data, pop, head, count, full, empty.
  - Synchronous reset; reused later by the transmit side.
- Synchroniser and FSM stay in tt_uio_byte_reader.

Test Plan:
- Reset, then single transfer: data=8'hA5, stb high. Required:
  - ack rises SYNC_STAGES+2 cycles after stb rises.
  - Drop stb: ack falls SYNC_STAGES+1 cycles later.
  - rd_valid=1 with rd_data=8'hA5; rx_count=1.
- Fill and backpressure, DEPTH=4:
  - Send 8'h01..8'h04 with no reads: fifo_count=4.
  - Send 8'h05: ack stays 0 and FSM is in HOLD.
  - Pulse rd_en once: 8'h01 pops; ack rises 2 cycles later; final contents 02,03,04,05.
- Simultaneous push and pop: FIFO holds 1 byte; a push coincides with rd_en. Required: fifo_count stays 1, rd_data advances to the new byte, order preserved.
- Empty read: rd_en=1 for 3 cycles on an empty FIFO. Required: fifo_count stays 0, rd_valid stays 0, no pointer movement.
- Reset with strobe held:
  - Assert rst during ACK with stb still high. Required: ack=0 next cycle, FIFO empty, no capture while stb stays high.
  - Drop then raise stb with 8'h3C: exactly one byte 8'h3C captured.
- rx_count wrap: 256 transfers with interleaved reads. Required: rx_count returns to 0 and no bytes are lost; the scoreboard matches all 256.

Source files
------------

// File: rtl/tt_uio_pkg.sv
// Shared definitions for the uio parallel byte interface: reader FSM encoding and pin map.
package tt_uio_pkg;

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_IDLE = 2'd1,
        ST_HOLD = 2'd2,
        ST_ACK  = 2'd3
    } rd_state_e;

    localparam int          STB_PIN      = 0;
    localparam int          ACK_PIN      = 7;
    localparam logic [7:0]  UIO_OE_INPUT = 8'h00;

endpackage

// File: rtl/tt_byte_fifo.sv
// Byte FIFO with show-ahead head, registered occupancy and synchronous active-high reset.
module tt_byte_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [7:0]    push_data_i,
    input  logic          pop_i,
    output logic [7:0]    head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_fire, pop_fire;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign push_fire = push_i && !full_o;
    assign pop_fire  = pop_i && !empty_o;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_fire)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_fire && !pop_fire)      count_q <= count_q + 1'b1;
            else if (pop_fire && !push_fire) count_q <= count_q - 1'b1;
        end
    end

    // NOTE: storage is not reset; entries are only visible once count says they were written.
    always_ff @(posedge clk) begin
        if (push_fire) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/tt_uio_byte_reader.sv
// Receive side of the uio byte interface: strobe synchroniser, 4-phase handshake FSM, byte FIFO.
module tt_uio_byte_reader
    import tt_uio_pkg::*;
#(
    parameter  int DEPTH       = 4,
    parameter  int SYNC_STAGES = 2,
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    bus_data_in,
    input  logic          bus_stb_in,
    output logic          bus_ack_out,
    output logic [7:0]    bus_oe,
    input  logic          rd_en,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic [CW-1:0] fifo_count,
    output logic [7:0]    rx_count
);

    rd_state_e              state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   stb_s;
    logic                   ack_q, ack_d;
    logic [7:0]             rx_count_q, rx_count_d;
    logic                   push;
    logic                   full, empty;

    assign stb_s = sync_q[SYNC_STAGES-1];

    // Synchroniser resets high so a strobe held through reset is never mistaken for a new request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ARM;
            sync_q     <= '1;
            ack_q      <= 1'b0;
            rx_count_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], bus_stb_in};
            ack_q      <= ack_d;
            rx_count_q <= rx_count_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            ST_ARM:  if (!stb_s) state_d = ST_IDLE;
            ST_IDLE: begin
                if (stb_s) begin
                    push    = !full;
                    state_d = full ? ST_HOLD : ST_ACK;
                end
            end
            ST_HOLD: begin
                if (!full) begin
                    push    = 1'b1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK:  if (!stb_s) state_d = ST_IDLE;
            default: state_d = ST_ARM;
        endcase
    end

    // Ack follows the push by one cycle and drops the cycle after the strobe release is seen.
    assign ack_d      = (state_q == ST_ACK) && stb_s;
    assign rx_count_d = rx_count_q + 8'(push);

    tt_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (bus_data_in),
        .pop_i       (rd_en),
        .head_o      (rd_data),
        .count_o     (fifo_count),
        .full_o      (full),
        .empty_o     (empty)
    );

    assign rd_valid    = !empty;
    assign bus_ack_out = ack_q;
    assign rx_count    = rx_count_q;
    assign bus_oe      = UIO_OE_INPUT;

endmodule

// File: tb/tb_tt_uio_byte_reader.sv
// Self-checking bench for tt_uio_byte_reader: transaction-level model compared every cycle plus directed checks.
module tb_tt_uio_byte_reader;
    import tt_uio_pkg::*;

    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    bus_data = 8'h00;
    logic [7:0]    ui_in = 8'h00;
    logic          rd_en = 1'b0;
    logic          ack;
    logic [7:0]    bus_oe, rd_data, rx_count;
    logic          rd_valid;
    logic [CW-1:0] fifo_count;
    logic [7:0]    uo_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tt_uio_byte_reader #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus_data_in (bus_data),
        .bus_stb_in  (ui_in[STB_PIN]),
        .bus_ack_out (ack),
        .bus_oe      (bus_oe),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .fifo_count  (fifo_count),
        .rx_count    (rx_count)
    );

    always_comb begin
        uo_out          = 8'h00;
        uo_out[ACK_PIN] = ack;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: the writer's strobe is seen SYNC cycles late; each request is
    // served by one push once there is room, and closes when the release is seen.
    logic [7:0] m_q[$];
    int         m_rx = 0;
    bit         m_ack = 0, released = 0, txn_open = 0, served = 0, live = 0;
    logic [SYNC-1:0] dly = '1;

    always @(posedge clk) begin
        bit seen, full, pop, push;
        if (rst) begin
            m_q.delete();
            m_rx = 0; m_ack = 0; released = 0; txn_open = 0; served = 0;
            dly = '1; live = 1;
        end else begin
            seen  = dly[SYNC-1];
            full  = (m_q.size() == DEPTH);
            pop   = rd_en && (m_q.size() != 0);
            push  = 0;
            m_ack = txn_open && served && seen;
            if (!released) released = !seen;
            else if (!txn_open) begin
                if (seen) begin txn_open = 1; push = !full; served = !full; end
            end else if (!served) begin
                push = !full; served = !full;
            end else if (!seen) txn_open = 0;
            if (pop)  void'(m_q.pop_front());
            if (push) begin m_q.push_back(bus_data); m_rx = (m_rx + 1) % 256; end
            dly = {dly[SYNC-2:0], ui_in[STB_PIN]};
        end
    end

    always @(negedge clk) begin
        if (live) begin
            check("ack",        ack, m_ack);
            check("uo_out",     uo_out, 8'(m_ack) << ACK_PIN);
            check("rd_valid",   rd_valid, m_q.size() != 0);
            check("fifo_count", fifo_count, m_q.size());
            check("rd_data",    rd_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
            check("rx_count",   rx_count, m_rx);
            check("bus_oe",     bus_oe, 8'h00);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wait_ack(input logic level, output int n);
        n = 0;
        do begin tick(); n++; end while (ack !== level && n < 60);
        check("ack_wait", ack, level);
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        bus_data = b;
        ui_in[STB_PIN] = 1'b1;
        wait_ack(1'b1, n);
        ui_in[STB_PIN] = 1'b0;
        wait_ack(1'b0, n);
    endtask

    task automatic pop_expect(input string name, input logic [7:0] b);
        check(name, rd_data, b);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        int n;
        logic [7:0] exp_q[$];
        int matched;

        // Reset values
        tick(3);
        check("rst_ack", ack, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_rx", rx_count, 0);
        check("rst_data", rd_data, 8'h00);
        rst = 1'b0;
        tick(SYNC + 2);

        // Single transfer with latency checks
        bus_data = 8'hA5;
        ui_in[STB_PIN] = 1'b1;
        wait_ack(1'b1, n);
        check("ack_rise_lat", n, SYNC + 2);
        ui_in[STB_PIN] = 1'b0;
        wait_ack(1'b0, n);
        check("ack_fall_lat", n, SYNC + 1);
        check("t1_valid", rd_valid, 1);
        check("t1_rx", rx_count, 1);
        pop_expect("t1_data", 8'hA5);

        // Fill and backpressure
        for (int i = 1; i <= 4; i++) send(8'(i));
        check("fill_count", fifo_count, 4);
        bus_data = 8'h05;
        ui_in[STB_PIN] = 1'b1;
        tick(10);
        check("hold_ack", ack, 0);
        check("hold_state", dut.state_q, ST_HOLD);
        check("hold_count", fifo_count, 4);
        check("hold_head", rd_data, 8'h01);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n = 1;
        while (ack !== 1'b1 && n < 60) begin tick(); n++; end
        check("bp_ack_lat", n, 3);
        ui_in[STB_PIN] = 1'b0;
        wait_ack(1'b0, n);
        for (int i = 2; i <= 5; i++) pop_expect("bp_order", 8'(i));
        check("bp_drained", fifo_count, 0);

        // Push coinciding with pop at occupancy 1
        send(8'h11);
        bus_data = 8'h22;
        ui_in[STB_PIN] = 1'b1;
        tick(SYNC);
        check("pp_head_before", rd_data, 8'h11);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("pp_count", fifo_count, 1);
        check("pp_head_after", rd_data, 8'h22);
        wait_ack(1'b1, n);
        ui_in[STB_PIN] = 1'b0;
        wait_ack(1'b0, n);
        pop_expect("pp_pop", 8'h22);

        // Read on empty FIFO
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("empty_count", fifo_count, 0);
            check("empty_valid", rd_valid, 0);
        end
        rd_en = 1'b0;

        // Reset during ACK with strobe held
        bus_data = 8'h77;
        ui_in[STB_PIN] = 1'b1;
        wait_ack(1'b1, n);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_ack", ack, 0);
        check("mr_count", fifo_count, 0);
        check("mr_rx", rx_count, 0);
        tick(10);
        check("mr_no_capture", fifo_count, 0);
        ui_in[STB_PIN] = 1'b0;
        tick(SYNC + 2);
        send(8'h3C);
        check("mr_one_byte", fifo_count, 1);
        check("mr_rx_one", rx_count, 1);
        pop_expect("mr_data", 8'h3C);

        // rx_count wrap over 256 transfers with interleaved reads
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(SYNC + 2);
        matched = 0;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i * 7 + 3);
            send(b);
            exp_q.push_back(b);
            if (i == 254) check("rx_255", rx_count, 255);
            if (exp_q.size() >= 2) begin
                if (rd_data === exp_q[0]) matched++;
                pop_expect("sb_data", exp_q.pop_front());
            end
        end
        while (exp_q.size() != 0) begin
            if (rd_data === exp_q[0]) matched++;
            pop_expect("sb_data", exp_q.pop_front());
        end
        check("rx_wrap", rx_count, 0);
        check("sb_matched", matched, 256);
        check("sb_empty", rd_valid, 0);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
